// File: rtl/vscpu_pkg.sv
// Shared definitions for the VerySimpleCPU program loader.
//   SYNC_BYTE      : first byte of every load frame
//   loader_state_t : loader FSM states
package vscpu_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/vscpu_word_packer.sv
// Byte-to-word packer with running XOR checksum.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drops any partial word and clears the checksum
//   byte_en    : accept byte_in this cycle
//   byte_in    : incoming byte, shifted in big-endian order
//   word_next  : the three held bytes followed by byte_in
//   word_done  : byte_in completes a 4-byte word this cycle
//   csum       : XOR of all bytes accepted since the last clear
module vscpu_word_packer
  import vscpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_done,
  output logic [7:0]  csum
);

  // Only three bytes are stored; the fourth is consumed straight from byte_in
  // by the loader when it registers the RAM write data.
  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_next = {shift_q, byte_in};
  assign word_done = byte_en && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
      csum    <= '0;
    end else if (byte_en) begin
      shift_q <= word_next[23:0];
      cnt_q   <= cnt_q + 2'd1;
      csum    <= csum ^ byte_in;
    end
  end

endmodule

// File: rtl/vscpu_boot_loader.sv
// Program loader for VerySimpleCPU: parses a framed byte stream, writes the
// image into block RAM from address 0 and releases the CPU reset once the
// image checksum matches.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   rx_valid, rx_data  : byte stream from the serial receiver
//   rx_ready           : byte accepted when rx_valid && rx_ready at posedge
//   wrEn, addr_toRAM,
//   data_toRAM         : RAM write port (addr/data hold while wrEn=0)
//   cpu_rst            : CPU reset, high until the image is verified
//   busy, done, error  : frame status
//
// state  | meaning
// IDLE   | hunting for the sync byte, other bytes dropped
// CNT_HI | waiting for word count high byte
// CNT_LO | waiting for word count low byte, range check
// DATA   | collecting data bytes into the current word
// WRITE  | one-cycle RAM write of the packed word
// CHK    | waiting for the checksum byte
// DONE   | image verified, CPU released
// ERROR  | frame rejected, CPU held in reset
module vscpu_boot_loader
  import vscpu_pkg::*;
#(
  parameter int SIZE = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            wrEn,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [31:0]     data_toRAM,
  output logic            cpu_rst,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam logic [31:0] CAP = 32'(1) << SIZE;

  loader_state_t state_q, state_d;
  logic [7:0]    cnt_hi_q;
  logic [15:0]   n_q;
  logic [SIZE:0] index_q;
  logic [31:0]   index_inc;
  logic [31:0]   count_in;
  logic          accept;
  logic          word_done;
  logic [31:0]   word_next;
  logic [7:0]    csum;

  assign rx_ready  = !rst && (state_q inside {IDLE, CNT_HI, CNT_LO, DATA, CHK});
  assign accept    = rx_valid && rx_ready;
  assign index_inc = 32'(index_q) + 32'd1;
  assign count_in  = {16'd0, cnt_hi_q, rx_data};

  vscpu_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == IDLE),
    .byte_en   (accept && (state_q == DATA)),
    .byte_in   (rx_data),
    .word_next (word_next),
    .word_done (word_done),
    .csum      (csum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      index_q    <= '0;
      addr_toRAM <= '0;
      data_toRAM <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:   index_q <= '0;
        CNT_HI: if (accept) cnt_hi_q <= rx_data;
        CNT_LO: if (accept) n_q <= {cnt_hi_q, rx_data};
        DATA: begin
          // Capture the write at the 4th byte so WRITE presents a stable word.
          if (word_done) begin
            addr_toRAM <= index_q[SIZE-1:0];
            data_toRAM <= word_next;
          end
        end
        WRITE:  index_q <= index_q + (SIZE+1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wrEn    = 1'b0;
    busy    = 1'b0;
    cpu_rst = 1'b1;
    done    = 1'b0;
    error   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_d = CNT_HI;
      end
      CNT_HI: begin
        busy = 1'b1;
        if (accept) state_d = CNT_LO;
      end
      CNT_LO: begin
        busy = 1'b1;
        if (accept) begin
          if (count_in > CAP)       state_d = ERROR;
          else if (count_in == '0)  state_d = CHK;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        busy = 1'b1;
        if (word_done) state_d = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        wrEn = 1'b1;
        state_d = (index_inc == {16'd0, n_q}) ? CHK : DATA;
      end
      CHK: begin
        busy = 1'b1;
        if (accept) state_d = (rx_data == csum) ? DONE : ERROR;
      end
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vscpu_boot_loader.sv
// Self-checking bench for vscpu_boot_loader (SIZE=4, capacity 16 words).
// A frame-level reference model predicts every output on every cycle; a few
// literal expectations pin the model on the documented example frames.
module tb_vscpu_boot_loader;

  localparam int SIZE = 4;
  localparam int CAP  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_ready, wrEn, cpu_rst, busy, done, error;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;

  vscpu_boot_loader #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .wrEn       (wrEn),
    .addr_toRAM (addr_toRAM),
    .data_toRAM (data_toRAM),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame position based) ----------------
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2, M_ERR = 3;
  bit          checking = 0;
  int          m_status = M_IDLE;
  bit          m_wpend  = 0;
  int          m_got    = 0;
  int          m_n      = 0;
  logic [7:0]  m_hi     = 0;
  logic [7:0]  m_xor    = 0;
  logic [31:0] m_word   = 0;
  logic [31:0] m_addr   = 0;
  logic [31:0] m_data   = 0;

  task automatic model_reset();
    m_status = M_IDLE; m_wpend = 0; m_got = 0; m_n = 0; m_hi = 0;
    m_xor = 0; m_word = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic consume(input logic [7:0] b);
    int di;
    if (m_status == M_IDLE) begin
      if (b == 8'hA5) begin m_status = M_BUSY; m_got = 0; m_xor = 0; m_word = 0; end
    end else if (m_status == M_BUSY) begin
      m_got++;
      if (m_got == 1) m_hi = b;
      else if (m_got == 2) begin
        m_n = int'({m_hi, b});
        if (m_n > CAP) m_status = M_ERR;
      end else begin
        di = m_got - 3;
        if (di < 4 * m_n) begin
          m_xor  = m_xor ^ b;
          m_word = {m_word[23:0], b};
          if (di % 4 == 3) begin
            m_wpend = 1;
            m_addr  = di / 4;
            m_data  = m_word;
          end
        end else begin
          m_status = (b == m_xor) ? M_DONE : M_ERR;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
      checking = 1;
    end else if (checking) begin
      if (m_wpend) m_wpend = 0;
      else if (rx_valid && (m_status == M_IDLE || m_status == M_BUSY)) consume(rx_data);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("wrEn",       32'(wrEn),       32'(m_wpend));
      chk("addr_toRAM", 32'(addr_toRAM), m_addr);
      chk("data_toRAM", data_toRAM,      m_data);
      chk("busy",       32'(busy),       32'(m_status == M_BUSY));
      chk("done",       32'(done),       32'(m_status == M_DONE));
      chk("error",      32'(error),      32'(m_status == M_ERR));
      chk("cpu_rst",    32'(cpu_rst),    32'(m_status != M_DONE));
      chk("rx_ready",   32'(rx_ready),
          32'(!rst && !m_wpend && (m_status == M_IDLE || m_status == M_BUSY)));
    end
  end

  // ---------------- RAM write log ----------------
  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];

  always @(posedge clk) begin
    if (wrEn === 1'b1) begin
      addr_log.push_back(32'(addr_toRAM));
      data_log.push_back(data_toRAM);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] frame[$];

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    addr_log.delete(); data_log.delete(); stalls = 0;
  endtask

  task automatic send(input bit gaps);
    int w;
    for (int i = 0; i < frame.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin rx_valid = 1'b0; @(posedge clk); #1; end
      end
      rx_valid = 1'b1; rx_data = frame[i];
      w = 0;
      forever begin
        @(posedge clk);
        if (rx_ready) break;
        stalls++; w++;
        if (w > 40) break;
      end
      if (w > 40) begin
        total++; bad++;
        $display("FAIL handshake_timeout: byte %0d not accepted after %0d cycles", i, w);
        #1 rx_valid = 1'b0;
        return;
      end
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic normal_frame();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02, 8'h80, 8'h14,
              8'h00, 8'h00, 8'h00, 8'h14, 8'h82};
  endtask

  task automatic check_normal_writes(input string tag);
    chk({tag, "_nwrites"}, 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      chk({tag, "_addr0"}, addr_log[0], 32'd0);
      chk({tag, "_data0"}, data_log[0], 32'h00028014);
      chk({tag, "_addr1"}, addr_log[1], 32'd1);
      chk({tag, "_data1"}, data_log[1], 32'h00000014);
    end
  endtask

  initial begin
    int n, ready_hi;
    bit good;
    logic [7:0] x, b;

    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("reset_wrEn", 32'(wrEn), 0);
    chk("reset_cpu_rst", 32'(cpu_rst), 1);
    chk("reset_data", data_toRAM, 0);

    // Normal load with leading noise, rx_valid held continuously.
    normal_frame();
    frame.push_front(8'h7F);
    frame.push_front(8'h3C);
    send(1'b0);
    @(negedge clk);
    check_normal_writes("normal");
    chk("normal_done", 32'(done), 1);
    chk("normal_cpu_rst", 32'(cpu_rst), 0);
    chk("normal_stalls", 32'(stalls), 2);

    // Bad checksum; further bytes must not be taken.
    do_reset();
    normal_frame();
    frame[11] = 8'h00;
    send(1'b1);
    @(negedge clk);
    check_normal_writes("badsum");
    chk("badsum_error", 32'(error), 1);
    chk("badsum_done", 32'(done), 0);
    chk("badsum_cpu_rst", 32'(cpu_rst), 1);
    rx_valid = 1'b1; rx_data = 8'hA5; ready_hi = 0;
    repeat (4) begin @(negedge clk); if (rx_ready) ready_hi++; end
    rx_valid = 1'b0;
    chk("badsum_ready_after", 32'(ready_hi), 0);

    // Empty image.
    do_reset();
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send(1'b0);
    @(negedge clk);
    chk("empty_done", 32'(done), 1);
    chk("empty_writes", 32'(addr_log.size()), 0);

    // Oversized count (17 > 16).
    do_reset();
    frame = '{8'hA5, 8'h00, 8'h11};
    send(1'b0);
    @(negedge clk);
    chk("over_error", 32'(error), 1);
    chk("over_writes", 32'(addr_log.size()), 0);

    // Reset after two data bytes, then a full frame.
    do_reset();
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h02};
    send(1'b0);
    do_reset();
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", 32'(addr_toRAM), 0);
    chk("midrst_writes", 32'(addr_log.size()), 0);
    normal_frame();
    send(1'b1);
    @(negedge clk);
    check_normal_writes("reload");
    chk("reload_done", 32'(done), 1);

    // Randomized frames; first one fills the RAM exactly.
    for (int it = 0; it < 24; it++) begin
      do_reset();
      n = (it == 0) ? CAP : (($urandom_range(0, 7) == 0) ? $urandom_range(17, 20)
                                                          : $urandom_range(0, CAP));
      good = (it == 0) || ($urandom_range(0, 3) != 0);
      frame.delete();
      if ($urandom_range(0, 1)) frame.push_back(8'(($urandom_range(0, 0) == 0) ? 8'h11 : 8'h22));
      frame.push_back(8'hA5);
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      x = 0;
      if (n <= CAP) begin
        for (int k = 0; k < 4 * n; k++) begin
          b = 8'($urandom);
          x ^= b;
          frame.push_back(b);
        end
        frame.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
      end
      send(it % 2 == 1);
      @(negedge clk);
      chk("rand_done", 32'(done), 32'(good && n <= CAP));
      chk("rand_writes", 32'(addr_log.size()), (n <= CAP) ? 32'(n) : 32'd0);
      if (it == 0 && addr_log.size() == CAP) chk("full_last_addr", addr_log[CAP-1], 32'd15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vscpu_boot_loader.md
# vscpu_boot_loader

Program loader for VerySimpleCPU, placed upstream of the block RAM and the CPU reset. It receives a framed byte stream from a serial receiver and packs it into 32-bit words. Each word is written into the RAM starting at address 0. The CPU is held in reset until the whole image has been written and its checksum matches.

## Interface
Parameters:
- SIZE, 14, RAM address width; image capacity is 2**SIZE words.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- rx_valid  in  1  byte strobe from the serial receiver.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a posedge.
- wrEn  out  1  RAM write enable.
- addr_toRAM  out  SIZE  RAM word address.
- data_toRAM  out  32  RAM write data.
- cpu_rst  out  1  reset to the CPU, active-high.
- busy  out  1  a frame is in progress.
- done  out  1  image loaded and verified.
- error  out  1  frame rejected.

## Operation
Frame format, in byte order:
- Sync byte 0xA5.
- Word count N, 16 bits, big-endian.
- N×4 data bytes; each word is big-endian, first byte goes to data_toRAM[31:24].
- One checksum byte, equal to the XOR of all data bytes.

States:
- IDLE: any byte other than 0xA5 is discarded. 0xA5 → CNT_HI.
- CNT_HI: store the high count byte → CNT_LO.
- CNT_LO: store the low count byte, then branch:
  - N > 2**SIZE → ERROR.
  - N == 0 → CHK.
  - otherwise → DATA.
- DATA: shift each byte into the 32-bit word and XOR it into the running checksum. The 4th byte of a word → WRITE.
- WRITE: wrEn=1 for exactly one cycle, with addr_toRAM = word index and data_toRAM = packed word. Increment the word index. If index == N → CHK, else → DATA.
- CHK: byte equals the running XOR → DONE, otherwise → ERROR.
- DONE: terminal until rst.
- ERROR: terminal until rst.

Outputs per state:
- rx_ready is 1 in IDLE, CNT_HI, CNT_LO, DATA and CHK. It is 0 in WRITE, DONE and ERROR, and 0 in any cycle where rst is high.
- busy is 1 in CNT_HI, CNT_LO, DATA, WRITE and CHK.
- cpu_rst is 1 in every state except DONE.
- done is 1 only in DONE.
- error is 1 only in ERROR.

Arithmetic and width rules:
- The word index is SIZE+1 bits wide, so N = 2**SIZE is legal and the final address is 2**SIZE−1.
- The checksum is 8 bits; sync, count and checksum bytes are excluded from it.
- addr_toRAM and data_toRAM hold their last values while wrEn=0.

## Timing
- Reset values: wrEn=0, addr_toRAM=0, data_toRAM=0, cpu_rst=1, busy=0, done=0, error=0, rx_ready=0. State returns to IDLE, and the index and checksum clear.
- Write latency: the 4th byte of a word is accepted at edge k. wrEn is high during the cycle between edge k and edge k+1, and the RAM captures the word at edge k+1. The next byte can be accepted at edge k+2 at the earliest.
- Completion: the checksum byte is accepted at edge k. done=1 and cpu_rst=0 immediately after edge k. The CPU sees its reset deasserted from the next posedge.
- Back-to-back bytes are accepted every cycle except during WRITE.
- rx_valid held high while rx_ready=0 does not consume the byte; the producer must hold it.
- Reset mid-frame has priority: the state returns to IDLE with reset values on the next edge, and any partial word is dropped. Words already in RAM are not erased. cpu_rst stays 1.

## Structure
- Shared package vscpu_pkg holds:
  - localparam SYNC_BYTE = 8'hA5;
  - the loader state enum: IDLE, CNT_HI, CNT_LO, DATA, WRITE, CHK, DONE, ERROR.
- One sub-module, vscpu_word_packer. It shifts in bytes, counts them modulo 4, flags word-complete, and keeps the running XOR. It has a clear input driven from IDLE.
- The FSM, word index and output registers stay in vscpu_boot_loader.

## Test plan
- Normal load: bytes A5 00 02 00 02 80 14 00 00 00 14 then checksum 0x82. Required response:
  - writes 0x00028014 @0, then 0x00000014 @1;
  - done=1, cpu_rst=0 after the checksum byte.
- Bad checksum: same frame with checksum 0x00.
  - Both words are written; error=1, cpu_rst stays 1, done=0.
  - Further bytes see rx_ready=0.
- Empty and oversized count:
  - A5 00 00 00 → done=1 with no wrEn pulse.
  - With SIZE=4, A5 00 11 → error=1 right after the count byte, with no writes.
- Noise and back-pressure:
  - 3C 7F before A5 are discarded.
  - rx_valid held continuously: exactly one stall cycle per word (rx_ready=0 during WRITE), and no byte is lost or duplicated.
- Reset mid-word: rst asserted after 2 data bytes of word 1.
  - Outputs return to reset values with no wrEn pulse.
  - A following complete frame loads correctly from address 0.
